// File: rtl/race_pkg.sv
// Shared types and widths for the drag-race sequencer.
package race_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_COUNTDOWN = 3'd1;
  localparam state_t ST_RACE      = 3'd2;
  localparam state_t ST_RESULTS   = 3'd3;
  localparam state_t ST_RESTART   = 3'd4;

  localparam int unsigned TIME_W  = 22;
  localparam int unsigned SEC_W   = 12;
  localparam int unsigned MS_W    = 10;
  localparam int unsigned PLACE_W = 3;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/race_timer.sv
// Millisecond/second stopwatch with clear, enable and saturation at 4095.999 s.
module race_timer
  import race_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [SEC_W-1:0] o_sec,
  output logic [MS_W-1:0]  o_ms
);

  logic [SEC_W-1:0] r_sec;
  logic [MS_W-1:0]  r_ms;
  logic             w_ms_wrap;
  logic             w_sat;

  assign w_ms_wrap = (r_ms == MS_W'(999));
  assign w_sat     = (r_sec == '1) && w_ms_wrap;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sec <= '0;
      r_ms  <= '0;
    end else if (i_clr) begin
      r_sec <= '0;
      r_ms  <= '0;
    end else if (i_en && !w_sat) begin
      if (w_ms_wrap) begin
        r_ms  <= '0;
        r_sec <= r_sec + 1'b1;
      end else begin
        r_ms <= r_ms + 1'b1;
      end
    end
  end

  assign o_sec = r_sec;
  assign o_ms  = r_ms;

endmodule

// File: rtl/race_controller.sv
// Game sequencer: ready gathering, start-light countdown, per-player race timing,
// competition ranking and a single restart tick back to the menu.
module race_controller
  import race_pkg::*;
#(
  parameter int unsigned NUM_PLAYERS     = 2,
  parameter int unsigned POS_W           = 32,
  parameter int unsigned FINISH_LINE_POS = 25000,
  parameter int unsigned COUNTDOWN_S     = 5,
  parameter int unsigned TICK_DIV        = 65000
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_PLAYERS-1:0]           ready,
  input  logic [NUM_PLAYERS-1:0]           ack,
  input  logic [NUM_PLAYERS*POS_W-1:0]     position,
  output logic [2:0]                       state,
  output logic [3:0]                       light_sec,
  output logic [NUM_PLAYERS-1:0]           race_enable,
  output logic [NUM_PLAYERS*TIME_W-1:0]    finish_time,
  output logic [NUM_PLAYERS*PLACE_W-1:0]   place,
  output logic                             race_done,
  output logic                             restart_tick
);

  localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [DIV_W-1:0]       r_div;
  logic                   w_ms_tick;
  logic                   w_start;
  logic                   w_in_race;
  logic                   w_cd_done;
  logic                   r_restart_tick;
  logic [SEC_W-1:0]       w_cd_sec;
  logic [MS_W-1:0]        w_cd_ms;
  logic [NUM_PLAYERS-1:0] w_cross;
  logic [NUM_PLAYERS-1:0] w_fin_now;
  logic [NUM_PLAYERS-1:0] w_fin_all;
  logic [NUM_PLAYERS-1:0] r_finished;
  logic [3:0]             r_place_ctr;
  logic [3:0]             w_fin_cnt;
  logic [PLACE_W-1:0]     r_place [NUM_PLAYERS];

  assign w_start   = (r_state == ST_IDLE) && (&ready);
  assign w_in_race = (r_state == ST_RACE);
  assign w_ms_tick = (r_state != ST_IDLE) && (r_div == DIV_W'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div <= '0;
    end else if (w_start || (r_state == ST_IDLE) || w_ms_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  race_timer u_cd_timer (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_start),
    .i_en  (w_ms_tick && (r_state == ST_COUNTDOWN)),
    .o_sec (w_cd_sec),
    .o_ms  (w_cd_ms)
  );

  assign w_cd_done = (w_cd_sec == SEC_W'(COUNTDOWN_S)) && (w_cd_ms == '0);
  assign light_sec = w_cd_sec[3:0];

  // A crossing counts only in RACE, so early arrivals finish on the first RACE cycle.
  assign w_fin_now   = {NUM_PLAYERS{w_in_race}} & ~r_finished & w_cross;
  assign w_fin_all   = r_finished | w_fin_now;
  assign race_enable = {NUM_PLAYERS{w_in_race}} & ~w_fin_all;
  assign w_fin_cnt   = popcount8(8'(w_fin_now));

  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_player
    logic [SEC_W-1:0] w_sec;
    logic [MS_W-1:0]  w_ms;

    assign w_cross[g] = (position[g*POS_W +: POS_W] >= POS_W'(FINISH_LINE_POS));

    race_timer u_timer (
      .clk   (clk),
      .rst   (rst),
      .i_clr (w_start),
      .i_en  (w_ms_tick && w_in_race && !w_fin_all[g]),
      .o_sec (w_sec),
      .o_ms  (w_ms)
    );

    assign finish_time[g*TIME_W +: TIME_W]  = {w_sec, w_ms};
    assign place[g*PLACE_W +: PLACE_W]      = r_place[g];
  end

  // Same-cycle finishers share a rank; the counter then skips past all of them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_finished  <= '0;
      r_place_ctr <= 4'd1;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        r_place[i] <= '0;
      end
    end else if (w_start) begin
      r_finished  <= '0;
      r_place_ctr <= 4'd1;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        r_place[i] <= '0;
      end
    end else begin
      r_finished  <= r_finished | w_fin_now;
      r_place_ctr <= r_place_ctr + w_fin_cnt;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        if (w_fin_now[i]) begin
          r_place[i] <= r_place_ctr[PLACE_W-1:0];
        end
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (&ready) w_state_next = ST_COUNTDOWN;
      end
      ST_COUNTDOWN: begin
        if (!(&ready))     w_state_next = ST_IDLE;
        else if (w_cd_done) w_state_next = ST_RACE;
      end
      ST_RACE: begin
        if (&w_fin_all) w_state_next = ST_RESULTS;
      end
      ST_RESULTS: begin
        if (&ack) w_state_next = ST_RESTART;
      end
      ST_RESTART: begin
        if ((ready == '0) && (ack == '0)) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= ST_IDLE;
      r_restart_tick <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_restart_tick <= (r_state == ST_RESULTS) && (&ack);
    end
  end

  assign state        = r_state;
  assign race_done    = (r_state == ST_RESULTS);
  assign restart_tick = r_restart_tick;

endmodule

// File: tb/tb_race_controller.sv
// Randomized bench for race_controller with a cycle-level arithmetic reference model.
module tb_race_controller;

  localparam int NP = 3;
  localparam int PW = 32;
  localparam int FL = 25000;
  localparam int CD = 5;
  localparam int TD = 2;
  localparam int KR = CD * 1000 * TD + 1;  // first RACE cycle after countdown entry

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CD   = 3'd1;
  localparam logic [2:0] S_RACE = 3'd2;
  localparam logic [2:0] S_RES  = 3'd3;
  localparam logic [2:0] S_RST  = 3'd4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NP-1:0]     ready = '0;
  logic [NP-1:0]     ack = '0;
  logic [NP*PW-1:0]  position = '0;
  logic [2:0]        state;
  logic [3:0]        light_sec;
  logic [NP-1:0]     race_enable;
  logic [NP*22-1:0]  finish_time;
  logic [NP*3-1:0]   place;
  logic              race_done;
  logic              restart_tick;

  int checks = 0;
  int failures = 0;
  int kc[NP];
  int kce[NP];
  int kend;
  logic [21:0] exp_ft[NP];
  logic [2:0]  exp_pl[NP];

  always #5 clk = ~clk;

  race_controller #(
    .NUM_PLAYERS     (NP),
    .POS_W           (PW),
    .FINISH_LINE_POS (FL),
    .COUNTDOWN_S     (CD),
    .TICK_DIV        (TD)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ready        (ready),
    .ack          (ack),
    .position     (position),
    .state        (state),
    .light_sec    (light_sec),
    .race_enable  (race_enable),
    .finish_time  (finish_time),
    .place        (place),
    .race_done    (race_done),
    .restart_tick (restart_tick)
  );

  // ms ticks that land in cycles [a, b-1] (a tick ends every TD-th cycle after entry)
  function automatic int ticks(int a, int b);
    return (b / TD) - (a / TD);
  endfunction

  function automatic logic [21:0] pack_ms(int ms);
    int s;
    s = ms / 1000;
    if (s > 4095) return {12'd4095, 10'd999};
    return {12'(s), 10'(ms % 1000)};
  endfunction

  function automatic logic [2:0] rank(int i);
    int r;
    r = 1;
    for (int j = 0; j < NP; j++) if (kce[j] < kce[i]) r++;
    return 3'(r);
  endfunction

  function automatic logic [PW-1:0] pos_for(int i, int k);
    if (k < kc[i])
      return ($urandom_range(0, 3) == 0) ? PW'(FL - 1) : PW'($urandom_range(0, FL - 1));
    if (k <= kce[i] + 2)
      return ($urandom_range(0, 1) == 0) ? PW'(FL) : PW'(FL + $urandom_range(1, 5000));
    return PW'($urandom);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one full race from IDLE to the first RESULTS cycle, checking every cycle.
  task automatic run_race(input string tag);
    logic [2:0]  es;
    logic [3:0]  els;
    logic [NP-1:0] een;
    logic [21:0] eft;
    logic [2:0]  epl;
    int lt;
    kend = 0;
    for (int i = 0; i < NP; i++) begin
      kce[i] = (kc[i] < KR) ? KR : kc[i];
      if (kce[i] + 1 > kend) kend = kce[i] + 1;
    end
    ready = '1;
    for (int k = 0; k <= kend; k++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NP; i++) position[i*PW +: PW] = pos_for(i, k);
      ack   = (k == kend) ? '0 : NP'($urandom);
      ready = (k >= KR && k < kend) ? NP'($urandom) : '1;
      #1;
      es = (k < KR) ? S_CD : (k < kend) ? S_RACE : S_RES;
      lt = (k / TD) / 1000;
      els = (lt > CD) ? 4'(CD) : 4'(lt);
      checks++;
      if (state !== es) begin
        failures++;
        $display("FAIL %s state k=%0d got=%0d exp=%0d", tag, k, state, es);
      end
      checks++;
      if (light_sec !== els) begin
        failures++;
        $display("FAIL %s light_sec k=%0d got=%0d exp=%0d", tag, k, light_sec, els);
      end
      checks++;
      if (race_done !== (es == S_RES) || restart_tick !== 1'b0) begin
        failures++;
        $display("FAIL %s done/tick k=%0d got=%b%b exp=%b0", tag, k, race_done, restart_tick,
                 (es == S_RES));
      end
      for (int i = 0; i < NP; i++) een[i] = (es == S_RACE) && (k < kce[i]);
      checks++;
      if (race_enable !== een) begin
        failures++;
        $display("FAIL %s race_enable k=%0d got=%b exp=%b", tag, k, race_enable, een);
      end
      for (int i = 0; i < NP; i++) begin
        eft = (k < KR) ? 22'd0 : pack_ms(ticks(KR, (k < kce[i]) ? k : kce[i]));
        epl = (k > kce[i]) ? rank(i) : 3'd0;
        checks++;
        if (finish_time[i*22 +: 22] !== eft) begin
          failures++;
          $display("FAIL %s finish_time%0d k=%0d got=%0d.%0d exp=%0d.%0d", tag, i, k,
                   finish_time[i*22+10 +: 12], finish_time[i*22 +: 10], eft[21:10], eft[9:0]);
        end
        checks++;
        if (place[i*3 +: 3] !== epl) begin
          failures++;
          $display("FAIL %s place%0d k=%0d got=%0d exp=%0d", tag, i, k, place[i*3 +: 3], epl);
        end
      end
    end
    for (int i = 0; i < NP; i++) begin
      exp_ft[i] = pack_ms(ticks(KR, kce[i]));
      exp_pl[i] = rank(i);
    end
  endtask

  task automatic test_reset();
    ready = '0;
    ack = '0;
    position = '0;
    #2 rst = 1'b0;
    #1;
    checks++;
    if (state !== S_IDLE || light_sec !== 4'd0 || race_enable !== '0 || finish_time !== '0 ||
        place !== '0 || race_done !== 1'b0 || restart_tick !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs got state=%0d ls=%0d en=%b ft=%h pl=%h done=%b tick=%b exp all 0",
               state, light_sec, race_enable, finish_time, place, race_done, restart_tick);
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    ready = 3'b011;
    step();
    checks++;
    if (state !== S_IDLE) begin
      failures++;
      $display("FAIL reset_partial_ready state got=%0d exp=%0d", state, S_IDLE);
    end
    ready = '0;
    step();
  endtask

  task automatic test_restart(input string tag);
    ack = 3'b011;
    step();
    checks++;
    if (state !== S_RES || restart_tick !== 1'b0 || race_done !== 1'b1) begin
      failures++;
      $display("FAIL %s partial_ack got state=%0d tick=%b done=%b exp 3/0/1", tag, state,
               restart_tick, race_done);
    end
    ack = '1;
    step();
    checks++;
    if (state !== S_RST || restart_tick !== 1'b1 || race_done !== 1'b0) begin
      failures++;
      $display("FAIL %s restart_entry got state=%0d tick=%b done=%b exp 4/1/0", tag, state,
               restart_tick, race_done);
    end
    for (int i = 0; i < NP; i++) begin
      checks++;
      if (finish_time[i*22 +: 22] !== exp_ft[i] || place[i*3 +: 3] !== exp_pl[i]) begin
        failures++;
        $display("FAIL %s hold%0d got ft=%h pl=%0d exp ft=%h pl=%0d", tag, i,
                 finish_time[i*22 +: 22], place[i*3 +: 3], exp_ft[i], exp_pl[i]);
      end
    end
    step();
    checks++;
    if (state !== S_RST || restart_tick !== 1'b0) begin
      failures++;
      $display("FAIL %s tick_one_cycle got state=%0d tick=%b exp 4/0", tag, state, restart_tick);
    end
    ack = '0;
    step();
    checks++;
    if (state !== S_RST) begin
      failures++;
      $display("FAIL %s wait_ready got state=%0d exp=%0d", tag, state, S_RST);
    end
    ready = '0;
    ack = 3'b100;
    step();
    checks++;
    if (state !== S_RST || restart_tick !== 1'b0) begin
      failures++;
      $display("FAIL %s wait_ack got state=%0d tick=%b exp 4/0", tag, state, restart_tick);
    end
    ack = '0;
    step();
    checks++;
    if (state !== S_IDLE || restart_tick !== 1'b0) begin
      failures++;
      $display("FAIL %s to_idle got state=%0d tick=%b exp 0/0", tag, state, restart_tick);
    end
  endtask

  task automatic test_countdown_race();
    kc[0] = KR + 2468;  // 1.234 s
    kc[1] = KR + 4000;  // 2.000 s
    kc[2] = KR + 5000;  // 2.500 s
    run_race("countdown_race");
    checks++;
    if (finish_time[21:0] !== {12'd1, 10'd234} || finish_time[43:22] !== {12'd2, 10'd0} ||
        finish_time[65:44] !== {12'd2, 10'd500}) begin
      failures++;
      $display("FAIL race_times got=%h exp=%h", finish_time,
               {12'd2, 10'd500, 12'd2, 10'd0, 12'd1, 10'd234});
    end
    checks++;
    if (place !== {3'd3, 3'd2, 3'd1}) begin
      failures++;
      $display("FAIL race_places got=%b exp=%b", place, {3'd3, 3'd2, 3'd1});
    end
    test_restart("race_restart");
  endtask

  task automatic test_abort();
    ready = '1;
    for (int k = 0; k <= 6000; k++) begin
      step();
      if (k == 5999 || k == 6000) begin
        checks++;
        if (state !== S_CD || light_sec !== 4'((k / TD) / 1000)) begin
          failures++;
          $display("FAIL abort_countdown k=%0d got state=%0d ls=%0d exp 1/%0d", k, state,
                   light_sec, (k / TD) / 1000);
        end
      end
    end
    ready = 3'b011;
    for (int n = 0; n < 4; n++) begin
      step();
      checks++;
      if (state !== S_IDLE || restart_tick !== 1'b0 || race_done !== 1'b0) begin
        failures++;
        $display("FAIL abort_idle n=%0d got state=%0d tick=%b exp 0/0", n, state, restart_tick);
      end
    end
    ready = '0;
    step();
  endtask

  task automatic test_tie();
    kc[0] = KR + 600;
    kc[1] = KR + 600;
    kc[2] = KR + 602;
    run_race("tie");
    checks++;
    if (place !== {3'd3, 3'd1, 3'd1}) begin
      failures++;
      $display("FAIL tie_places got=%b exp=%b", place, {3'd3, 3'd1, 3'd1});
    end
    checks++;
    if (finish_time[21:0] !== {12'd0, 10'd300} || finish_time[65:44] !== {12'd0, 10'd301}) begin
      failures++;
      $display("FAIL tie_times got=%h exp p0=300ms p2=301ms", finish_time);
    end
    test_restart("tie_restart");
  endtask

  task automatic test_reset_mid_race();
    position = '0;
    ready = '1;
    for (int k = 0; k <= KR + 20; k++) step();
    checks++;
    if (state !== S_RACE || finish_time[21:0] !== {12'd0, 10'd10}) begin
      failures++;
      $display("FAIL midrace_pre got state=%0d ft0=%h exp 2/%h", state, finish_time[21:0],
               {12'd0, 10'd10});
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (state !== S_IDLE || light_sec !== 4'd0 || race_enable !== '0 || finish_time !== '0 ||
        place !== '0 || race_done !== 1'b0 || restart_tick !== 1'b0) begin
      failures++;
      $display("FAIL midrace_reset got state=%0d ls=%0d en=%b ft=%h pl=%h exp all 0", state,
               light_sec, race_enable, finish_time, place);
    end
    ready = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    step();
    checks++;
    if (state !== S_IDLE || light_sec !== 4'd0) begin
      failures++;
      $display("FAIL midrace_release got state=%0d ls=%0d exp 0/0", state, light_sec);
    end
  endtask

  task automatic test_random();
    int r;
    for (int it = 0; it < 2; it++) begin
      for (int i = 0; i < NP; i++) begin
        r = $urandom_range(0, 9);
        kc[i] = (r == 0) ? KR - 4 : KR + r * 113;
      end
      if (it == 0) kc[0] = KR - 4;  // guarantee one early arrival
      run_race("random");
      test_restart("random_restart");
    end
  endtask

  initial begin
    test_reset();
    test_countdown_race();
    test_abort();
    test_tie();
    test_reset_mid_race();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
